// File: rtl/multi_debounce.sv
// N-channel key debouncer: 2-flop sync, tick-sampled shift registers with hysteresis,
// registered press/release pulses and per-channel auto-repeat.
module multi_debounce #(
   parameter int unsigned NCH        = 5,
   parameter int unsigned TICK_DIV   = 2097152,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned EXCLUSIVE  = 1,
   parameter int unsigned HOLD_TICKS = 64,
   parameter int unsigned RATE_TICKS = 16
) (
   input  logic           sysclk,
   input  logic           rst_n,
   input  logic [NCH-1:0] raw_i,
   input  logic           repeat_en,
   output logic [NCH-1:0] level_o,
   output logic [NCH-1:0] press_o,
   output logic [NCH-1:0] release_o,
   output logic           tick_o
);

   localparam int unsigned TW   = $clog2(TICK_DIV);
   localparam int unsigned RMAX = (HOLD_TICKS > RATE_TICKS) ? HOLD_TICKS : RATE_TICKS;
   localparam int unsigned CW   = $clog2(RMAX + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [NCH-1:0]   sync_a;
   logic [NCH-1:0]   sync_b;
   logic [NCH-1:0]   qual;
   logic [DEPTH-1:0] shreg     [NCH];
   logic [1:0]       state     [NCH];
   logic [1:0]       state_nx  [NCH];
   logic [CW-1:0]    rcnt      [NCH];
   logic [CW-1:0]    rcnt_nx   [NCH];
   logic [CW-1:0]    rcnt_inc  [NCH];
   logic [CW-1:0]    rcnt_lim  [NCH];
   logic [NCH-1:0]   all_one;
   logic [NCH-1:0]   all_zero;
   logic [NCH-1:0]   rise;
   logic [NCH-1:0]   fall;
   logic [NCH-1:0]   fire;

   assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
   assign tick_o = tick;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         sync_a   <= '0;
         sync_b   <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         sync_a   <= raw_i;
         sync_b   <= sync_a;
      end
   end

   // In exclusive mode a key only qualifies while every other synchronised key is low.
   always_comb begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         qual[ch] = sync_b[ch] &
                    ((EXCLUSIVE == 0) || ((sync_b & ~(NCH'(1) << ch)) == '0));
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned ch = 0; ch < NCH; ch++) shreg[ch] <= '0;
      end else if (tick) begin
         for (int unsigned ch = 0; ch < NCH; ch++)
            shreg[ch] <= {shreg[ch][DEPTH-2:0], qual[ch]};
      end
   end

   always_comb begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         all_one[ch]  = &shreg[ch];
         all_zero[ch] = ~|shreg[ch];
      end
   end

   assign rise = ~level_o & all_one;
   assign fall =  level_o & all_zero;

   // Counters saturate; the compare uses the incremented value so a fire lands on the tick edge.
   always_comb begin
      for (int unsigned ch = 0; ch < NCH; ch++) begin
         rcnt_inc[ch] = (rcnt[ch] == '1) ? rcnt[ch] : rcnt[ch] + 1'b1;
         rcnt_lim[ch] = (state[ch] == ST_HOLD) ? CW'(HOLD_TICKS) : CW'(RATE_TICKS);
         state_nx[ch] = state[ch];
         rcnt_nx[ch]  = rcnt[ch];
         fire[ch]     = 1'b0;
         case (state[ch])
            ST_IDLE: begin
               if (rise[ch]) begin
                  state_nx[ch] = ST_HOLD;
                  rcnt_nx[ch]  = '0;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               if (fall[ch] || !level_o[ch]) begin
                  state_nx[ch] = ST_IDLE;
                  rcnt_nx[ch]  = '0;
               end else if (!repeat_en) begin
                  state_nx[ch] = ST_HOLD;
                  rcnt_nx[ch]  = '0;
               end else if (tick) begin
                  if (rcnt_inc[ch] >= rcnt_lim[ch]) begin
                     fire[ch]     = 1'b1;
                     rcnt_nx[ch]  = '0;
                     state_nx[ch] = ST_REPEAT;
                  end else begin
                     rcnt_nx[ch] = rcnt_inc[ch];
                  end
               end
            end
            default: begin
               state_nx[ch] = ST_IDLE;
               rcnt_nx[ch]  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         level_o   <= '0;
         press_o   <= '0;
         release_o <= '0;
         for (int unsigned ch = 0; ch < NCH; ch++) begin
            state[ch] <= ST_IDLE;
            rcnt[ch]  <= '0;
         end
      end else begin
         for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (all_one[ch])       level_o[ch] <= 1'b1;
            else if (all_zero[ch]) level_o[ch] <= 1'b0;
            state[ch] <= state_nx[ch];
            rcnt[ch]  <= rcnt_nx[ch];
         end
         press_o   <= rise | (fire & ~fall);
         release_o <= fall;
      end
   end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed + random bench for multi_debounce; two instances (exclusive / non-exclusive)
// checked every cycle against a run-length / tick-count reference model.
module tb_multi_debounce;

   localparam int NCH = 5;
   localparam int TD  = 4;
   localparam int DP  = 3;
   localparam int HT  = 4;
   localparam int RT  = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] raw;
   logic           rep_en;
   logic [NCH-1:0] lvl_x, prs_x, rel_x, lvl_n, prs_n, rel_n;
   logic           tk_x, tk_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multi_debounce #(.NCH(NCH), .TICK_DIV(TD), .DEPTH(DP), .EXCLUSIVE(1),
                    .HOLD_TICKS(HT), .RATE_TICKS(RT)) dut_x (
      .sysclk(clk), .rst_n(rst_n), .raw_i(raw), .repeat_en(rep_en),
      .level_o(lvl_x), .press_o(prs_x), .release_o(rel_x), .tick_o(tk_x));

   multi_debounce #(.NCH(NCH), .TICK_DIV(TD), .DEPTH(DP), .EXCLUSIVE(0),
                    .HOLD_TICKS(HT), .RATE_TICKS(RT)) dut_n (
      .sysclk(clk), .rst_n(rst_n), .raw_i(raw), .repeat_en(rep_en),
      .level_o(lvl_n), .press_o(prs_n), .release_o(rel_n), .tick_o(tk_n));

   // Reference model: index 0 = exclusive instance, 1 = non-exclusive instance.
   int             cyc;
   logic [NCH-1:0] m_s1, m_s2;
   logic           m_val  [2][NCH];
   int             m_run  [2][NCH];
   int             m_held [2][NCH];
   logic [NCH-1:0] m_lvl [2];
   logic [NCH-1:0] m_prs [2];
   logic [NCH-1:0] m_rel [2];

   task automatic model_reset();
      cyc  = 0;
      m_s1 = '0;
      m_s2 = '0;
      for (int k = 0; k < 2; k++) begin
         m_lvl[k] = '0;
         m_prs[k] = '0;
         m_rel[k] = '0;
         for (int ch = 0; ch < NCH; ch++) begin
            m_val[k][ch]  = 1'b0;
            m_run[k][ch]  = DP;
            m_held[k][ch] = 0;
         end
      end
   endtask

   task automatic model_edge();
      bit             t;
      logic           q, old, nw, f;
      logic [NCH-1:0] others;
      t = ((cyc % TD) == TD - 1);
      for (int k = 0; k < 2; k++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            others     = m_s2;
            others[ch] = 1'b0;
            q   = m_s2[ch] && (k == 1 || others == '0);
            old = m_lvl[k][ch];
            nw  = (m_run[k][ch] >= DP) ? m_val[k][ch] : old;
            f   = 1'b0;
            if (!old || !nw || !rep_en) begin
               m_held[k][ch] = 0;
            end else if (t) begin
               m_held[k][ch] = m_held[k][ch] + 1;
               f = (m_held[k][ch] == HT) ||
                   (m_held[k][ch] > HT && ((m_held[k][ch] - HT) % RT) == 0);
            end
            m_prs[k][ch] = (nw && !old) || f;
            m_rel[k][ch] = old && !nw;
            m_lvl[k][ch] = nw;
            if (t) begin
               if (q == m_val[k][ch]) begin
                  if (m_run[k][ch] < DP) m_run[k][ch] = m_run[k][ch] + 1;
               end else begin
                  m_val[k][ch] = q;
                  m_run[k][ch] = 1;
               end
            end
         end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic et;
      et = ((cyc % TD) == TD - 1);
      chk("lvl_x", lvl_x, m_lvl[0]);
      chk("prs_x", prs_x, m_prs[0]);
      chk("rel_x", rel_x, m_rel[0]);
      chk("tick_x", NCH'(tk_x), NCH'(et));
      chk("lvl_n", lvl_n, m_lvl[1]);
      chk("prs_n", prs_n, m_prs[1]);
      chk("rel_n", rel_n, m_rel[1]);
      chk("tick_n", NCH'(tk_n), NCH'(et));
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (rst_n) model_edge();
         @(negedge clk);
         check_all();
      end
   endtask

   initial begin
      int cnt_a, cnt_b;
      rst_n  = 1'b0;
      raw    = '0;
      rep_en = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      step(2);
      rst_n = 1'b1;

      // Single steady key: one press, other channels quiet.
      raw   = 5'b00100;
      cnt_a = 0;
      for (int i = 0; i < 24; i++) begin
         step(1);
         cnt_a += int'(prs_n[2]);
      end
      chk("d1_press_cnt", NCH'(cnt_a), NCH'(1));
      chk("d1_lvl", lvl_x, 5'b00100);
      raw = '0;
      step(24);
      chk("d1_lvl_off", lvl_n, '0);

      // Bounce every 5 cycles, then stable.
      cnt_a = 0;
      for (int i = 0; i < 40; i++) begin
         raw[0] = ((i / 5) % 2 == 0);
         step(1);
         cnt_a += int'(prs_n[0]);
      end
      chk("bounce_no_press", NCH'(cnt_a), NCH'(0));
      raw[0] = 1'b1;
      cnt_a  = 0;
      for (int i = 0; i < 24; i++) begin
         step(1);
         cnt_a += int'(prs_n[0]);
      end
      chk("bounce_press_cnt", NCH'(cnt_a), NCH'(1));
      raw = '0;
      step(24);

      // Chord: exclusive instance drops key 1 and never raises key 3.
      raw = 5'b00010;
      step(24);
      chk("chord_pre", lvl_x, 5'b00010);
      raw   = 5'b01010;
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 28; i++) begin
         step(1);
         cnt_a += int'(rel_x[1]);
         cnt_b += int'(lvl_x[3]);
      end
      chk("chord_rel_cnt", NCH'(cnt_a), NCH'(1));
      chk("chord_k3_never", NCH'(cnt_b), NCH'(0));
      chk("chord_lvl_x", lvl_x, '0);
      chk("chord_lvl_n", lvl_n, 5'b01010);
      raw = '0;
      step(24);

      // Auto-repeat on a held key, then disable and re-enable.
      rep_en = 1'b1;
      raw    = 5'b10000;
      cnt_a  = 0;
      for (int i = 0; i < 80; i++) begin
         step(1);
         cnt_a += int'(prs_n[4]);
      end
      chk("rep_pulses", NCH'(cnt_a >= 5), NCH'(1));
      rep_en = 1'b0;
      step(4);
      cnt_a = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         cnt_a += int'(prs_n[4]);
      end
      chk("rep_off_quiet", NCH'(cnt_a), NCH'(0));
      rep_en = 1'b1;
      step(40);
      raw = '0;
      step(20);

      // Asynchronous reset mid-REPEAT, then a fresh debounce.
      raw = 5'b10000;
      step(60);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      rep_en = 1'b0;
      step(3);
      rst_n = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         cnt_a += int'(prs_n[4]);
      end
      chk("rst_fresh_press", NCH'(cnt_a), NCH'(1));
      raw = '0;
      step(20);

      // Random keys and repeat enable.
      for (int i = 0; i < 800; i++) begin
         for (int ch = 0; ch < NCH; ch++)
            if ($urandom_range(0, 29) == 0) raw[ch] = ~raw[ch];
         if ($urandom_range(0, 59) == 0) rep_en = ~rep_en;
         step(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
